hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the five-stage pipeline (F, D, E, M, W). It tracks the destination register, write-enable and load flag of every instruction in E, M and W in an internal shadow pipeline. From that state it drives fetch/decode stalls, decode/execute flushes and the E-stage operand-forwarding selects. Two modes are available: stall-only interlocking, or full forwarding with load-use stall. Saturating stall and flush counters are included for performance measurement.

## Interface
- `FORWARD_EN`, 1, 1 = forward from M/W with load-use stall; 0 = no forwarding, stall until the producer leaves M.
- `REG_AW`, 5, register address width.
- `CNT_W`, 16, width of each performance counter.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `Rs1D`, `Rs2D` in REG_AW: source registers of the instruction in D.
- `RdD` in REG_AW: destination register of the instruction in D.
- `RegWriteD` in 1: instruction in D writes the register file.
- `ResultSrcD` in 2: 2'b01 marks a load.
- `PCSrcE` in 1: branch/jump taken, resolved in E.
- `StallF`, `StallD` out 1: hold the PC register and the IF/ID register.
- `FlushD`, `FlushE` out 1: clear the IF/ID register and the ID/EX register.
- `ForwardAE`, `ForwardBE` out 2: E operand select. 00 = register file, 01 = ResultW, 10 = ALUResultM.
- `stall_count` out CNT_W: number of cycles with StallD=1.
- `flush_count` out CNT_W: number of cycles with PCSrcE=1.

## Operation
- The shadow pipeline holds one entry per stage: E, M, W. Each entry is {valid, rd, wr, ld}. Rs1E and Rs2E are also registered.
- On each edge:
  - W ← M.
  - M ← E.
  - E ← bubble (valid=0) if FlushE=1. Otherwise E ← {1, RdD, RegWriteD, ResultSrcD==2'b01, Rs1D, Rs2D}.
- An entry counts as a producer only when valid=1, wr=1 and rd≠0. x0 never creates a hazard and is never forwarded.
- The register file is write-through. A W-stage producer is never a D-stage hazard.
- FORWARD_EN=1:
  - `hazD` is true when the E entry is a load producer and rd matches Rs1D or Rs2D.
  - ForwardAE is 10 if the M producer's rd equals Rs1E. Otherwise it is 01 if the W producer's rd equals Rs1E. Otherwise it is 00. M has priority over W.
  - ForwardBE follows the same rule using Rs2E.
- FORWARD_EN=0:
  - `hazD` is true when the E or M producer's rd matches Rs1D or Rs2D.
  - ForwardAE and ForwardBE are constant 00.
- Control equations:
  - StallF = StallD = hazD & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | hazD.
- A stall inserts a bubble into E while holding F and D. The stall repeats each cycle until hazD clears.
- Simultaneous stall and flush: the flush wins. No stall is asserted and both D and E are cleared.
- Counters:
  - stall_count increments on each cycle with StallD=1.
  - flush_count increments on each cycle with PCSrcE=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Reset (asynchronous, immediate): all shadow entries go invalid, Rs1E/Rs2E go to 0, and both counters go to 0.
  - Consequence: StallF, StallD, FlushD, FlushE are 0 and ForwardAE/BE are 00 while rst is high. This holds as long as PCSrcE=0.
- Reset mid-stall: the stall is dropped in the same cycle. On the first edge after release, the D instruction enters E normally.
- All control outputs are combinational from the D-stage inputs, PCSrcE and registered state. There are no registered outputs except the counters.
- Counters update on the edge that ends the counted cycle. They are visible in the next cycle.
- Load-use latency with FORWARD_EN=1: exactly 1 stall cycle. In the following cycle ForwardXE=01 (load data from W).
- Dependent distances with FORWARD_EN=0 (producer ahead of the consumer):
  - distance 1: 2 stall cycles.
  - distance 2: 1 stall cycle.
  - distance ≥3: no stall.
- A flush bubble in E is invalid. It never triggers a hazard or forwarding in later cycles.

## Test plan
- FORWARD_EN=1, `add x5` then `sub x6,x5,x1` back-to-back → no stall; consumer in E sees ForwardAE=10.
  - Add one independent instruction between them → ForwardAE=01.
- FORWARD_EN=1, `lw x7` then `add x8,x7,x7` → exactly one cycle of StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01; stall_count=1.
- FORWARD_EN=0, `addi x3` then `add x4,x3,x0` → StallD high for 2 cycles, ForwardAE stays 00; stall_count=2.
  - Distance 3 → no stall.
- Producer with rd=x0 followed by a reader of x0 → no stall, ForwardAE=00 in both modes.
- Load-use hazard with PCSrcE=1 in the same cycle → StallD=0, FlushD=FlushE=1; stall_count unchanged, flush_count +1.
- CNT_W=2, drive 5 load-use stalls → stall_count saturates at 3.
  - Assert rst mid-stall → StallD=0 and counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the pipeline datapath and the hazard scoreboard.
// The datapath (master) presents the D-stage instruction and branch outcome;
// the scoreboard (slave) returns stall/flush/forward controls and counters.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] RdD;
  logic              RegWriteD;
  logic [1:0]        ResultSrcD;
  logic              PCSrcE;
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    input  stall_count, flush_count
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    output stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for a 5-stage pipeline using an E/M/W shadow pipeline.
// Controls are combinational from D inputs, PCSrcE and shadow state; counters are registered.
// A taken branch overrides a stall: D and E are flushed and no stall is raised.
module hazard_scoreboard #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wr;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t            e_q, m_q, w_q;
  logic              e_ld;
  logic [REG_AW-1:0] rs1_e, rs2_e;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic e_prod, m_prod, w_prod;
  logic e_hit_d, m_hit_d;
  logic haz_d, stall, flush_e;
  logic [1:0] fwd_a, fwd_b;

  // x0 is hardwired to zero, so an entry writing it is never a producer
  assign e_prod = e_q.vld & e_q.wr & (e_q.rd != '0);
  assign m_prod = m_q.vld & m_q.wr & (m_q.rd != '0);
  assign w_prod = w_q.vld & w_q.wr & (w_q.rd != '0);

  assign e_hit_d = e_prod & ((e_q.rd == hz.Rs1D) | (e_q.rd == hz.Rs2D));
  assign m_hit_d = m_prod & ((m_q.rd == hz.Rs1D) | (m_q.rd == hz.Rs2D));

  // D-stage hazard and E-stage operand selects; W never blocks D since the RF writes through
  always_comb begin
    haz_d = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FORWARD_EN) begin
      haz_d = e_hit_d & e_ld;
      if (m_prod && (m_q.rd == rs1_e))      fwd_a = 2'b10;
      else if (w_prod && (w_q.rd == rs1_e)) fwd_a = 2'b01;
      if (m_prod && (m_q.rd == rs2_e))      fwd_b = 2'b10;
      else if (w_prod && (w_q.rd == rs2_e)) fwd_b = 2'b01;
    end else begin
      haz_d = e_hit_d | m_hit_d;
    end
  end

  assign stall   = haz_d & ~hz.PCSrcE;
  assign flush_e = hz.PCSrcE | haz_d;

  assign hz.StallF      = stall;
  assign hz.StallD      = stall;
  assign hz.FlushD      = hz.PCSrcE;
  assign hz.FlushE      = flush_e;
  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

  // Advance the shadow pipeline; a flush or stall drops a bubble into E
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      e_ld  <= 1'b0;
      rs1_e <= '0;
      rs2_e <= '0;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      if (flush_e) begin
        e_q   <= '0;
        e_ld  <= 1'b0;
        rs1_e <= '0;
        rs2_e <= '0;
      end else begin
        e_q   <= '{vld: 1'b1, rd: hz.RdD, wr: hz.RegWriteD};
        e_ld  <= (hz.ResultSrcD == 2'b01);
        rs1_e <= hz.Rs1D;
        rs2_e <= hz.Rs2D;
      end
    end
  end

  // Saturating performance counters for stall cycles and taken-branch cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX))     stall_cnt <= stall_cnt + CNT_ONE;
      if (hz.PCSrcE && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, interlock-only, 2-bit counters)
// share one D-stage stimulus stream; expectations are queued by the stimulus process
// and drained by a monitor at each falling edge (or on an explicit mid-cycle probe).
module tb_hazard_scoreboard;

    localparam int F_STALLD = 0, F_STALLF = 1, F_FLUSHD = 2, F_FLUSHE = 3;
    localparam int F_FWDA = 4, F_FWDB = 5, F_SCNT = 6, F_FCNT = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic probe = 1'b0;
    logic done = 1'b0;
    logic [4:0] rs1d = '0, rs2d = '0, rdd = '0;
    logic regwrited = 1'b0;
    logic [1:0] resultsrcd = 2'b00;
    logic pcsrce = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) ifb ();
    hazard_scoreboard_if #(.REG_AW(5), .CNT_W(2))  ifc ();

    assign ifa.Rs1D = rs1d;  assign ifa.Rs2D = rs2d;  assign ifa.RdD = rdd;
    assign ifa.RegWriteD = regwrited;  assign ifa.ResultSrcD = resultsrcd;  assign ifa.PCSrcE = pcsrce;
    assign ifb.Rs1D = rs1d;  assign ifb.Rs2D = rs2d;  assign ifb.RdD = rdd;
    assign ifb.RegWriteD = regwrited;  assign ifb.ResultSrcD = resultsrcd;  assign ifb.PCSrcE = pcsrce;
    assign ifc.Rs1D = rs1d;  assign ifc.Rs2D = rs2d;  assign ifc.RdD = rdd;
    assign ifc.RegWriteD = regwrited;  assign ifc.ResultSrcD = resultsrcd;  assign ifc.PCSrcE = pcsrce;

    hazard_scoreboard #(.FORWARD_EN(1'b1), .REG_AW(5), .CNT_W(16)) dut_fwd (.clk(clk), .rst(rst), .hz(ifa));
    hazard_scoreboard #(.FORWARD_EN(1'b0), .REG_AW(5), .CNT_W(16)) dut_stl (.clk(clk), .rst(rst), .hz(ifb));
    hazard_scoreboard #(.FORWARD_EN(1'b1), .REG_AW(5), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .hz(ifc));

    logic [15:0] obs [3][8];

    // Flatten every instance's outputs into one table for the monitor
    always_comb begin
        obs[0][F_STALLD] = {15'b0, ifa.StallD};   obs[0][F_STALLF] = {15'b0, ifa.StallF};
        obs[0][F_FLUSHD] = {15'b0, ifa.FlushD};   obs[0][F_FLUSHE] = {15'b0, ifa.FlushE};
        obs[0][F_FWDA]   = {14'b0, ifa.ForwardAE}; obs[0][F_FWDB]  = {14'b0, ifa.ForwardBE};
        obs[0][F_SCNT]   = ifa.stall_count;        obs[0][F_FCNT]  = ifa.flush_count;
        obs[1][F_STALLD] = {15'b0, ifb.StallD};   obs[1][F_STALLF] = {15'b0, ifb.StallF};
        obs[1][F_FLUSHD] = {15'b0, ifb.FlushD};   obs[1][F_FLUSHE] = {15'b0, ifb.FlushE};
        obs[1][F_FWDA]   = {14'b0, ifb.ForwardAE}; obs[1][F_FWDB]  = {14'b0, ifb.ForwardBE};
        obs[1][F_SCNT]   = ifb.stall_count;        obs[1][F_FCNT]  = ifb.flush_count;
        obs[2][F_STALLD] = {15'b0, ifc.StallD};   obs[2][F_STALLF] = {15'b0, ifc.StallF};
        obs[2][F_FLUSHD] = {15'b0, ifc.FlushD};   obs[2][F_FLUSHE] = {15'b0, ifc.FlushE};
        obs[2][F_FWDA]   = {14'b0, ifc.ForwardAE}; obs[2][F_FWDB]  = {14'b0, ifc.ForwardBE};
        obs[2][F_SCNT]   = {14'b0, ifc.stall_count}; obs[2][F_FCNT] = {14'b0, ifc.flush_count};
    end

    typedef struct packed {
        logic [1:0]  d;
        logic [3:0]  f;
        logic [15:0] v;
    } exp_t;

    exp_t  exp_q [$];
    string nm_q  [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input int d, input int f, input int v, input string nm);
        exp_t e;
        e.d = d[1:0];
        e.f = f[3:0];
        e.v = v[15:0];
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Monitor: compare every queued expectation against the sampled outputs
    always @(negedge clk or posedge probe) begin
        exp_t  e;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            n_checks++;
            if (obs[e.d][e.f] !== e.v) begin
                n_fail++;
                $display("FAIL %s (dut %0d field %0d): got %0d expected %0d", n, e.d, e.f, obs[e.d][e.f], e.v);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time
    initial begin
        #100000;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog: stimulus did not complete in time");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    // Present one D-stage instruction for the cycle following the next rising edge
    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic pc);
        @(posedge clk);
        #1;
        rs1d = r1;  rs2d = r2;  rdd = rd;
        regwrited = wr;
        resultsrcd = ld ? 2'b01 : 2'b00;
        pcsrce = pc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rs1d = '0;  rs2d = '0;  rdd = '0;  regwrited = 1'b0;  resultsrcd = 2'b00;  pcsrce = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk(d, F_STALLD, 0, "rst_stalld");
            chk(d, F_FLUSHE, 0, "rst_flushe");
            chk(d, F_FWDA,   0, "rst_fwda");
            chk(d, F_SCNT,   0, "rst_stall_count");
            chk(d, F_FCNT,   0, "rst_flush_count");
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // ---- forwarding instance ----
        do_reset();
        step(1, 2, 5, 1, 0, 0);  chk(0, F_STALLD, 0, "fwd_producer_nostall");
        step(5, 1, 6, 1, 0, 0);  chk(0, F_STALLD, 0, "fwd_b2b_nostall");
        step(0, 0, 0, 0, 0, 0);  chk(0, F_FWDA, 2, "fwd_b2b_fwda_m");  chk(0, F_FWDB, 0, "fwd_b2b_fwdb");
        step(1, 2, 5, 1, 0, 0);
        step(10, 11, 9, 1, 0, 0);
        step(5, 1, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);  chk(0, F_FWDA, 1, "fwd_dist2_fwda_w");  chk(0, F_FWDB, 0, "fwd_dist2_fwdb");
        step(0, 0, 5, 1, 0, 0);
        step(0, 0, 5, 1, 0, 0);
        step(5, 5, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);  chk(0, F_FWDA, 2, "fwd_m_over_w_a");  chk(0, F_FWDB, 2, "fwd_m_over_w_b");
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // load-use
        step(1, 0, 7, 1, 1, 0);  chk(0, F_STALLD, 0, "lu_load_nostall");
        step(7, 7, 8, 1, 0, 0);
        chk(0, F_STALLD, 1, "lu_stalld");  chk(0, F_STALLF, 1, "lu_stallf");
        chk(0, F_FLUSHE, 1, "lu_flushe");  chk(0, F_FLUSHD, 0, "lu_flushd");
        step(7, 7, 8, 1, 0, 0);
        chk(0, F_STALLD, 0, "lu_one_cycle_only");  chk(0, F_FLUSHE, 0, "lu_flushe_clear");
        chk(0, F_SCNT, 1, "lu_stall_count");
        step(0, 0, 0, 0, 0, 0);
        chk(0, F_FWDA, 1, "lu_fwda_w");  chk(0, F_FWDB, 1, "lu_fwdb_w");  chk(0, F_SCNT, 1, "lu_stall_count_hold");
        // x0 producer (a load, so it would stall if x0 were not excluded)
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 10, 1, 0, 0); chk(0, F_STALLD, 0, "fwd_x0_nostall");
        step(0, 0, 0, 0, 0, 0);  chk(0, F_FWDA, 0, "fwd_x0_nofwd");
        // load-use coinciding with a taken branch
        step(1, 0, 7, 1, 1, 0);
        step(7, 7, 8, 1, 0, 1);
        chk(0, F_STALLD, 0, "br_stalld");  chk(0, F_STALLF, 0, "br_stallf");
        chk(0, F_FLUSHD, 1, "br_flushd");  chk(0, F_FLUSHE, 1, "br_flushe");
        step(0, 0, 0, 0, 0, 0);
        chk(0, F_STALLD, 0, "br_after_stalld");  chk(0, F_SCNT, 1, "br_stall_count");
        chk(0, F_FCNT, 1, "br_flush_count");

        // ---- interlock-only instance ----
        do_reset();
        step(0, 0, 3, 1, 0, 0);  chk(1, F_STALLD, 0, "il_producer_nostall");
        step(3, 0, 4, 1, 0, 0);
        chk(1, F_STALLD, 1, "il_d1_stall1");  chk(1, F_FLUSHE, 1, "il_d1_flushe");
        chk(1, F_FLUSHD, 0, "il_d1_flushd");  chk(1, F_FWDA, 0, "il_d1_fwda");
        step(3, 0, 4, 1, 0, 0);  chk(1, F_STALLD, 1, "il_d1_stall2");  chk(1, F_SCNT, 1, "il_d1_cnt1");
        step(3, 0, 4, 1, 0, 0);  chk(1, F_STALLD, 0, "il_d1_release");  chk(1, F_SCNT, 2, "il_d1_cnt2");
        step(0, 0, 0, 0, 0, 0);  chk(1, F_FWDA, 0, "il_fwda_const");  chk(1, F_SCNT, 2, "il_d1_cnt_hold");
        step(0, 0, 3, 1, 0, 0);
        step(0, 0, 9, 1, 0, 0);
        step(3, 0, 4, 1, 0, 0);  chk(1, F_STALLD, 1, "il_d2_stall");
        step(3, 0, 4, 1, 0, 0);  chk(1, F_STALLD, 0, "il_d2_release");  chk(1, F_SCNT, 3, "il_d2_cnt");
        step(0, 0, 3, 1, 0, 0);
        step(0, 0, 9, 1, 0, 0);
        step(0, 0, 10, 1, 0, 0);
        step(3, 0, 4, 1, 0, 0);  chk(1, F_STALLD, 0, "il_d3_nostall");
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 10, 1, 0, 0); chk(1, F_STALLD, 0, "il_x0_nostall");
        step(0, 0, 0, 0, 0, 0);  chk(1, F_FWDA, 0, "il_x0_fwda");

        // ---- 2-bit counter instance ----
        do_reset();
        step(0, 0, 0, 0, 0, 1);  chk(2, F_FLUSHD, 1, "sat_branch_flushd");  chk(2, F_FLUSHE, 1, "sat_branch_flushe");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 7, 1, 1, 0);
            step(7, 7, 8, 1, 0, 0);  chk(2, F_STALLD, 1, "sat_lu_stall");
            step(7, 7, 8, 1, 0, 0);  chk(2, F_STALLD, 0, "sat_lu_release");
            chk(2, F_SCNT, (i < 2) ? i + 1 : 3, "sat_stall_count");
        end
        chk(2, F_FCNT, 1, "sat_flush_count");
        // reset asserted in the middle of a stall cycle
        step(1, 0, 7, 1, 1, 0);
        step(7, 7, 8, 1, 0, 0);  chk(2, F_STALLD, 1, "mid_pre_stall");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ((ifc.StallD !== 1'b0) || (ifc.StallF !== 1'b0) ||
            (ifc.stall_count !== 2'd0) || (ifc.flush_count !== 2'd0)) begin
            n_fail++;
            $display("FAIL mid_rst_immediate: StallD=%0b StallF=%0b stall_count=%0d flush_count=%0d",
                     ifc.StallD, ifc.StallF, ifc.stall_count, ifc.flush_count);
        end
        chk(2, F_STALLD, 0, "mid_rst_stalld");  chk(2, F_STALLF, 0, "mid_rst_stallf");
        chk(2, F_SCNT, 0, "mid_rst_stall_count");  chk(2, F_FCNT, 0, "mid_rst_flush_count");
        probe = 1'b1;
        #1;
        probe = 1'b0;
        rst = 1'b0;
        // the held add x8 enters E on the first edge after release
        step(8, 0, 9, 1, 0, 0);  chk(1, F_STALLD, 1, "post_rst_entry_il");  chk(2, F_STALLD, 0, "post_rst_c_nostall");
        step(0, 0, 0, 0, 0, 0);  chk(2, F_FWDA, 2, "post_rst_entry_fwd");
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
